program_counter: RTL and testbench



---
 rtl/pc_pkg.sv | 29 ++
 rtl/ulapc.sv | 38 +++
 rtl/program_counter.sv | 61 ++++++
 tb/tb_program_counter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter: default widths, reset vector,
// sequential step and the next-PC source encoding.
package pc_pkg;

    localparam int unsigned XLEN_DEFAULT         = 64;
    localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h0;
    localparam int unsigned STEP_DEFAULT         = 4;

    // Source of the next PC value
    typedef enum logic [1:0] {
        SEQ    = 2'b00,  // pc + STEP
        BRANCH = 2'b01,  // pc + imm
        JALR   = 2'b10   // (rs1 + imm) & ~1
    } next_pc_sel_e;

    // sel_jalr wins over soma_imm; neither set means sequential flow.
    function automatic next_pc_sel_e decode_sel(input logic soma_imm, input logic sel_jalr);
        next_pc_sel_e sel;
        if (sel_jalr) begin
            sel = JALR;
        end else if (soma_imm) begin
            sel = BRANCH;
        end else begin
            sel = SEQ;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ulapc.sv
// Next-PC adder and multiplexer. Purely combinational; all sums wrap modulo
// 2^XLEN with the carry-out dropped.
module ulapc
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned STEP = STEP_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            soma_imm,
    input  logic            sel_jalr,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] seq_sum;
    logic [XLEN-1:0] br_sum;
    logic [XLEN-1:0] jalr_sum;
    next_pc_sel_e    sel;

    assign sel      = decode_sel(soma_imm, sel_jalr);
    assign seq_sum  = pc + XLEN'(STEP);
    assign br_sum   = pc + imm;
    assign jalr_sum = rs1 + imm;

    // Pick the next PC; the jalr target always has bit 0 cleared.
    always_comb begin
        next_pc = seq_sum;
        unique case (sel)
            SEQ:     next_pc = seq_sum;
            BRANCH:  next_pc = br_sum;
            JALR:    next_pc = {jalr_sum[XLEN-1:1], 1'b0};
            default: next_pc = seq_sum;
        endcase
    end

endmodule

// File: rtl/program_counter.sv
// Program counter register. The next-PC value comes from ulapc; this module
// holds only the PC register, its update enable and synchronous reset.
// Optional feature macro PC_MISALIGN_CHECK_EN: adds output 'misaligned' and
// blocks updates to a next-PC that is not 4-byte aligned.
module program_counter
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int unsigned     STEP         = STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            atualiza_pc,
    input  logic            soma_imm,
    input  logic            sel_jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] dout,
    output logic [XLEN-1:0] dout_next
`ifdef PC_MISALIGN_CHECK_EN
    ,
    output logic            misaligned
`endif
);

    logic [XLEN-1:0] pc_q;
    logic            load_en;

    ulapc #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_ulapc (
        .pc       (pc_q),
        .imm      (imm),
        .rs1      (rs1),
        .soma_imm (soma_imm),
        .sel_jalr (sel_jalr),
        .next_pc  (dout_next)
    );

`ifdef PC_MISALIGN_CHECK_EN
    // A misaligned target is flagged and the update is suppressed.
    assign misaligned = (dout_next[1:0] != 2'b00);
    assign load_en    = atualiza_pc & ~misaligned;
`else
    assign load_en    = atualiza_pc;
`endif

    // PC register: reset takes priority over any pending update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_VECTOR;
        end else if (load_en) begin
            pc_q <= dout_next;
        end
    end

    assign dout = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: each directed vector pushes the
// expected dout/dout_next for its cycle; a monitor pops and compares on the
// falling edge. Build with PC_MISALIGN_CHECK_EN to exercise the alignment guard.
module tb_program_counter;

    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk;
    logic        reset;
    logic        atualiza_pc;
    logic        soma_imm;
    logic        sel_jalr;
    logic [63:0] imm;
    logic [63:0] rs1;
    logic [63:0] dout;
    logic [63:0] dout_next;
`ifdef PC_MISALIGN_CHECK_EN
    logic        misaligned;
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [63:0] d;
        logic [63:0] n;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    program_counter dut (
        .clk         (clk),
        .reset       (reset),
        .atualiza_pc (atualiza_pc),
        .soma_imm    (soma_imm),
        .sel_jalr    (sel_jalr),
        .imm         (imm),
        .rs1         (rs1),
        .dout        (dout),
        .dout_next   (dout_next)
`ifdef PC_MISALIGN_CHECK_EN
        ,
        .misaligned  (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs just after the rising edge and queue the
    // values expected at the following falling edge.
    task automatic vec(input string name, input logic r, input logic u, input logic s,
                       input logic j, input logic [63:0] i, input logic [63:0] rs,
                       input logic [63:0] ed, input logic [63:0] en);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = r;
        atualiza_pc = u;
        soma_imm    = s;
        sel_jalr    = j;
        imm         = i;
        rs1         = rs;
        e.name = name;
        e.d    = ed;
        e.n    = en;
        q.push_back(e);
    endtask

    // Monitor: compare whatever the stimulus has queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_checks++;
                if (dout === e.d) n_pass++;
                else $display("FAIL %s dout: got %h want %h", e.name, dout, e.d);
                n_checks++;
                if (dout_next === e.n) n_pass++;
                else $display("FAIL %s dout_next: got %h want %h", e.name, dout_next, e.n);
`ifdef PC_MISALIGN_CHECK_EN
                n_checks++;
                if (misaligned === (e.n[1:0] != 2'b00)) n_pass++;
                else $display("FAIL %s misaligned: got %b want %b", e.name, misaligned,
                              (e.n[1:0] != 2'b00));
`endif
            end
        end
    end

    initial begin
        int guard;
        reset       = 1'b0;
        atualiza_pc = 1'b0;
        soma_imm    = 1'b0;
        sel_jalr    = 1'b0;
        imm         = '0;
        rs1         = '0;

        //   name          rst upd soma jalr imm            rs1             dout        dout_next
        vec("reset",       0,  0,  0,   0,   64'h0,         64'h0,          64'h0,      64'h4);
        vec("seq0",        1,  1,  0,   0,   64'h0,         64'h0,          64'h0,      64'h4);
        vec("seq1",        1,  1,  0,   0,   64'h0,         64'h0,          64'h4,      64'h8);
        vec("seq2",        1,  1,  0,   0,   64'h0,         64'h0,          64'h8,      64'hC);
        vec("seq3_hold",   1,  0,  0,   0,   64'h0,         64'h0,          64'hC,      64'h10);
        vec("jalr_to_100", 1,  1,  0,   1,   64'h0,         64'h100,        64'hC,      64'h100);
        vec("br_m8",       1,  1,  1,   0,   -64'sd8,       64'h0,          64'h100,    64'hF8);
        vec("br_p20",      1,  1,  1,   0,   64'h20,        64'h0,          64'hF8,     64'h118);
        vec("hold0",       1,  0,  1,   0,   64'h10,        64'h0,          64'h118,    64'h128);
        vec("hold1",       1,  0,  0,   0,   64'h10,        64'h0,          64'h118,    64'h11C);
        vec("hold2",       1,  0,  1,   0,   -64'sd280,     64'h0,          64'h118,    64'h0);
        vec("hold3",       1,  0,  1,   0,   64'h1,         64'h0,          64'h118,    64'h119);
        vec("hold4",       1,  0,  0,   1,   64'h0,         64'h7,          64'h118,    64'h6);
        vec("jalr",        1,  1,  1,   1,   64'h2,         64'h1003,       64'h118,    64'h1004);
        vec("jalr_after",  1,  0,  0,   0,   64'h0,         64'h0,          64'h1004,   64'h1008);
        vec("ld_top",      1,  1,  0,   1,   64'h0,         TOP,            64'h1004,   TOP);
        vec("wrap_seq",    1,  1,  0,   0,   64'h0,         64'h0,          TOP,        64'h0);
        vec("neg_wrap",    1,  0,  1,   0,   -64'sd4,       64'h0,          64'h0,      TOP);
        vec("pre_rst",     1,  1,  0,   0,   64'h0,         64'h0,          64'h0,      64'h4);
        vec("rst_upd",     0,  1,  1,   0,   64'h40,        64'h0,          64'h4,      64'h44);
        vec("post_rst",    1,  0,  0,   0,   64'h0,         64'h0,          64'h0,      64'h4);
        vec("odd_br",      1,  1,  1,   0,   64'h2,         64'h0,          64'h0,      64'h2);
        vec("after_odd",   1,  0,  0,   0,   64'h0,         64'h0,
            MIS_EN ? 64'h0 : 64'h2, MIS_EN ? 64'h4 : 64'h6);

        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
